// File: rtl/cordic_pkg.sv
// cordic_pkg: shared fixed-point definitions for the CORDIC cosine pipeline.
// Word format is 33-bit two's complement Q2.31 (bit 32 sign, bit 31 weight 1).
package cordic_pkg;

  localparam int WIDTH = 33;
  localparam int FRAC  = 31;

  // One fixed-point word; signedness is applied explicitly where it matters.
  typedef logic [WIDTH-1:0] fx_t;

  // pi/2 in Q2.31.
  localparam fx_t PI_OVER_2  = 33'h0_C90FDAA2;

  // Starting value of the angle accumulator fed to the first stage.
  localparam fx_t INIT_ANGLE = 33'h0_00000000;

  // atan(2^-(i+2)) in Q2.31, i = 0..13, i.e. shift amounts 2..15.
  localparam fx_t arctan [0:13] = '{
    33'h0_1F5B7600,
    33'h0_0FEADD50,
    33'h0_07FD56EE,
    33'h0_03FFAAB7,
    33'h0_01FFF556,
    33'h0_00FFFEAB,
    33'h0_007FFFD5,
    33'h0_003FFFFB,
    33'h0_001FFFFF,
    33'h0_00100000,
    33'h0_00080000,
    33'h0_00040000,
    33'h0_00020000,
    33'h0_00010000
  };

  // Signed strict greater-than on two fixed-point words.
  function automatic logic fx_gt(input fx_t a, input fx_t b);
    return ($signed(a) > $signed(b));
  endfunction

  // Modulo-2^33 add and subtract; overflow wraps by design.
  function automatic fx_t fx_add(input fx_t a, input fx_t b);
    return a + b;
  endfunction

  function automatic fx_t fx_sub(input fx_t a, input fx_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/cordic_pipe_stage_if.sv
// cordic_pipe_stage_if: data bundle flowing between chained CORDIC stages.
// The master drives the incoming vector/angle/tags and observes the results;
// the slave (a stage) consumes the inputs and produces the registered outputs.
interface cordic_pipe_stage_if;
  import cordic_pkg::*;

  // Stage inputs
  logic       sign_in;
  logic       USE_SIN_in;
  logic [7:0] ite;
  fx_t        target_in;
  fx_t        arctan_in_1;
  fx_t        arctan_in_2;
  fx_t        curr_angle_in;
  fx_t        x_in;
  fx_t        y_in;

  // Stage outputs
  logic       sign_out;
  logic       USE_SIN_out;
  fx_t        target_out;
  fx_t        curr_angle_out;
  fx_t        x_out;
  fx_t        y_out;

  modport master (
    output sign_in, USE_SIN_in, ite, target_in, arctan_in_1, arctan_in_2,
           curr_angle_in, x_in, y_in,
    input  sign_out, USE_SIN_out, target_out, curr_angle_out, x_out, y_out
  );

  modport slave (
    input  sign_in, USE_SIN_in, ite, target_in, arctan_in_1, arctan_in_2,
           curr_angle_in, x_in, y_in,
    output sign_out, USE_SIN_out, target_out, curr_angle_out, x_out, y_out
  );

endinterface

// File: rtl/cordic_micro_rot.sv
// cordic_micro_rot: one combinational CORDIC micro-rotation.
// d=1 rotates counter-clockwise (angle grows), d=0 clockwise.
// Build option CORDIC_STAGE_ROUND_EN: round the shifted vector operands
// half-up instead of truncating; the angle path is never rounded.
module cordic_micro_rot
  import cordic_pkg::*;
(
  input  fx_t        x_i,
  input  fx_t        y_i,
  input  fx_t        angle_i,
  input  logic       d_i,
  input  logic [3:0] s_i,
  input  fx_t        atan_i,
  output fx_t        x_o,
  output fx_t        y_o,
  output fx_t        angle_o
);

  // Arithmetic right shift of a vector component by s bit positions.
  function automatic fx_t shr(input fx_t v, input logic [3:0] s);
    fx_t sh;
`ifdef CORDIC_STAGE_ROUND_EN
    fx_t below;
`endif
    sh = $signed(v) >>> s;
`ifdef CORDIC_STAGE_ROUND_EN
    // Add back the most significant discarded bit (half-up rounding).
    if (s != 4'd0) begin
      below = v >> (s - 4'd1);
      sh    = sh + {32'd0, below[0]};
    end else begin
      sh = v;
    end
`endif
    return sh;
  endfunction

  fx_t x_sh_s;
  fx_t y_sh_s;

  // Cross-coupled shift-and-add for one rotation step.
  always_comb begin
    x_sh_s  = shr(x_i, s_i);
    y_sh_s  = shr(y_i, s_i);
    x_o     = x_i;
    y_o     = y_i;
    angle_o = angle_i;
    if (d_i) begin
      x_o     = fx_sub(x_i, y_sh_s);
      y_o     = fx_add(y_i, x_sh_s);
      angle_o = fx_add(angle_i, atan_i);
    end else begin
      x_o     = fx_add(x_i, y_sh_s);
      y_o     = fx_sub(y_i, x_sh_s);
      angle_o = fx_sub(angle_i, atan_i);
    end
  end

endmodule

// File: rtl/cordic_pipe_stage.sv
// cordic_pipe_stage: two chained CORDIC micro-rotations per clock, registered.
// Direction of the second rotation, and the direction handed to the next
// stage, come from a signed strict compare of the target against the
// accumulated angle (ties rotate negative). Target and sin/cos tag ride along.
// Build option CORDIC_STAGE_ROUND_EN selects half-up rounding of the vector
// shifts inside cordic_micro_rot.
module cordic_pipe_stage
  import cordic_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cordic_pipe_stage_if.slave bus
);

  logic [3:0] s1_s;
  logic [3:0] s2_s;
  fx_t        x1_s;
  fx_t        y1_s;
  fx_t        a1_s;
  fx_t        x2_s;
  fx_t        y2_s;
  fx_t        a2_s;
  logic       d1_s;
  logic       d2_s;

  assign s1_s = bus.ite[7:4];
  assign s2_s = bus.ite[3:0];

  cordic_micro_rot u_rot1 (
    .x_i     (bus.x_in),
    .y_i     (bus.y_in),
    .angle_i (bus.curr_angle_in),
    .d_i     (bus.sign_in),
    .s_i     (s1_s),
    .atan_i  (bus.arctan_in_1),
    .x_o     (x1_s),
    .y_o     (y1_s),
    .angle_o (a1_s)
  );

  cordic_micro_rot u_rot2 (
    .x_i     (x1_s),
    .y_i     (y1_s),
    .angle_i (a1_s),
    .d_i     (d1_s),
    .s_i     (s2_s),
    .atan_i  (bus.arctan_in_2),
    .x_o     (x2_s),
    .y_o     (y2_s),
    .angle_o (a2_s)
  );

  fx_t  x_d, x_q;
  fx_t  y_d, y_q;
  fx_t  angle_d, angle_q;
  fx_t  target_d, target_q;
  logic sign_d, sign_q;
  logic use_sin_d, use_sin_q;

  // Direction decisions and next-state values for the output registers.
  always_comb begin
    d1_s      = fx_gt(bus.target_in, a1_s);
    d2_s      = fx_gt(bus.target_in, a2_s);
    x_d       = x2_s;
    y_d       = y2_s;
    angle_d   = a2_s;
    sign_d    = d2_s;
    target_d  = bus.target_in;
    use_sin_d = bus.USE_SIN_in;
  end

  // Output registers; synchronous reset clears everything and wins over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= 33'h0_00000000;
      y_q       <= 33'h0_00000000;
      angle_q   <= 33'h0_00000000;
      target_q  <= 33'h0_00000000;
      sign_q    <= 1'b0;
      use_sin_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      angle_q   <= angle_d;
      target_q  <= target_d;
      sign_q    <= sign_d;
      use_sin_q <= use_sin_d;
    end
  end

  assign bus.x_out          = x_q;
  assign bus.y_out          = y_q;
  assign bus.curr_angle_out = angle_q;
  assign bus.target_out     = target_q;
  assign bus.sign_out       = sign_q;
  assign bus.USE_SIN_out    = use_sin_q;

endmodule

// File: tb/tb_cordic_pipe_stage.sv
// tb_cordic_pipe_stage: directed and randomized checks of cordic_pipe_stage
// against an integer-arithmetic model of the two micro-rotations.
module tb_cordic_pipe_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cordic_pipe_stage_if bus ();

  cordic_pipe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reduce an integer to its 33-bit two's complement value (wraps mod 2^33).
  function automatic longint sx(input longint v);
    longint m;
    m = v & longint'(64'h1_FFFF_FFFF);
    if (m[32]) m = m - longint'(64'h2_0000_0000);
    return m;
  endfunction

  // Scaled division by 2^s, floored, or rounded half-up when that build is on.
  function automatic longint ashr(input longint v, input int s);
`ifdef CORDIC_STAGE_ROUND_EN
    if (s > 0) return (v + (longint'(1) << (s - 1))) >>> s;
`endif
    return v >>> s;
  endfunction

  function automatic void rot(input longint x, input longint y, input longint a,
                              input bit d, input int s, input longint at,
                              output longint xo, output longint yo, output longint ao);
    if (d) begin
      xo = sx(x - ashr(y, s));
      yo = sx(y + ashr(x, s));
      ao = sx(a + at);
    end else begin
      xo = sx(x + ashr(y, s));
      yo = sx(y - ashr(x, s));
      ao = sx(a - at);
    end
  endfunction

  function automatic logic [32:0] w33(input longint v);
    return v[32:0];
  endfunction

  function automatic longint val(input logic [32:0] w);
    return sx(longint'({31'd0, w}));
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Apply one input vector for one clock and check all outputs against the model.
  task automatic step(input string tag, input logic r, input logic sg, input logic us,
                      input logic [7:0] it, input logic [32:0] tg,
                      input logic [32:0] at1, input logic [32:0] at2,
                      input logic [32:0] ang, input logic [32:0] xx, input logic [32:0] yy);
    longint x1, y1, a1, x2, y2, a2;
    bit     d1, d2;
    rst               = r;
    bus.sign_in       = sg;
    bus.USE_SIN_in    = us;
    bus.ite           = it;
    bus.target_in     = tg;
    bus.arctan_in_1   = at1;
    bus.arctan_in_2   = at2;
    bus.curr_angle_in = ang;
    bus.x_in          = xx;
    bus.y_in          = yy;
    rot(val(xx), val(yy), val(ang), sg, int'(it[7:4]), val(at1), x1, y1, a1);
    d1 = (val(tg) > a1);
    rot(x1, y1, a1, d1, int'(it[3:0]), val(at2), x2, y2, a2);
    d2 = (val(tg) > a2);
    @(posedge clk);
    #1;
    if (r) begin
      x2 = 0; y2 = 0; a2 = 0; d2 = 1'b0;
    end
    chk({tag, "_x"},      bus.x_out,          w33(x2));
    chk({tag, "_y"},      bus.y_out,          w33(y2));
    chk({tag, "_angle"},  bus.curr_angle_out, w33(a2));
    chk({tag, "_sign"},   {32'd0, bus.sign_out},    {32'd0, d2});
    chk({tag, "_target"}, bus.target_out,     r ? 33'h0 : tg);
    chk({tag, "_usesin"}, {32'd0, bus.USE_SIN_out}, {32'd0, (r ? 1'b0 : us)});
  endtask

  function automatic logic [32:0] rnd33();
    return {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 32'($urandom)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;

    // Reset state with non-zero inputs present.
    step("reset", 1'b1, 1'b1, 1'b1, 8'h23, 33'h0_40000000, 33'h0_1F5B7600,
         33'h0_0FEADD50, 33'h0_12345678, 33'h0_80000000, 33'h1_80000000);

    // Positive rotation with the documented response.
    step("pos", 1'b0, 1'b1, 1'b0, 8'h23, 33'h0_40000000, 33'h0_1F5B7600,
         33'h0_0FEADD50, 33'h0, 33'h0_80000000, 33'h0);
    chk("pos_x_lit", bus.x_out, 33'h0_7C000000);
    chk("pos_y_lit", bus.y_out, 33'h0_30000000);
    chk("pos_a_lit", bus.curr_angle_out, 33'h0_2F465350);
    chk("pos_s_lit", {32'd0, bus.sign_out}, 33'h1);

    // Negative rotation with the documented response.
    step("neg", 1'b0, 1'b0, 1'b1, 8'h23, 33'h0, 33'h0_1F5B7600,
         33'h0_0FEADD50, 33'h0, 33'h0_80000000, 33'h0);
    chk("neg_x_lit", bus.x_out, 33'h0_84000000);
    chk("neg_y_lit", bus.y_out, 33'h1_F0000000);
    chk("neg_a_lit", bus.curr_angle_out, 33'h1_F08F6750);
    chk("neg_s_lit", {32'd0, bus.sign_out}, 33'h1);

    // Target equal to the final angle: tie rotates negative.
    step("eq2", 1'b0, 1'b1, 1'b0, 8'h23, 33'h0_2F465350, 33'h0_1F5B7600,
         33'h0_0FEADD50, 33'h0, 33'h0_80000000, 33'h0);
    chk("eq2_a_lit", bus.curr_angle_out, 33'h0_2F465350);
    chk("eq2_s_lit", {32'd0, bus.sign_out}, 33'h0);

    // Target equal to the intermediate angle: second rotation goes negative.
    step("eq1", 1'b0, 1'b1, 1'b0, 8'h23, 33'h0_1F5B7600, 33'h0_1F5B7600,
         33'h0_0FEADD50, 33'h0, 33'h0_80000000, 33'h0);
    chk("eq1_a_lit", bus.curr_angle_out, 33'h0_0F7098B0);
    chk("eq1_s_lit", {32'd0, bus.sign_out}, 33'h1);

    // Rounding of a small shifted operand (second shift leaves y unchanged).
    step("rnd", 1'b0, 1'b1, 1'b0, 8'h2F, 33'h0, 33'h0, 33'h0, 33'h0,
         33'h0_00000006, 33'h0);
`ifdef CORDIC_STAGE_ROUND_EN
    chk("rnd_y_lit", bus.y_out, 33'h0_00000002);
`else
    chk("rnd_y_lit", bus.y_out, 33'h0_00000001);
`endif
    step("rnd0", 1'b0, 1'b1, 1'b0, 8'h20, 33'h0, 33'h0, 33'h0, 33'h0,
         33'h0_00000006, 33'h0);

    // Zero shifts with large operands exercise wrap-around.
    step("wrap", 1'b0, 1'b1, 1'b1, 8'h00, 33'h0_7FFFFFFF, 33'h0_C90FDAA2,
         33'h0_C90FDAA2, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF);

    // Back-to-back random stream with toggling tag and a mid-stream reset.
    for (int i = 0; i < 120; i++) begin
      step((i == 60) ? "rst_mid" : "rand", (i == 60) ? 1'b1 : 1'b0,
           1'($urandom_range(1, 0)), i[0], 8'($urandom),
           rnd33(), rnd33(), rnd33(), rnd33(), rnd33(), rnd33());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
